// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, status flags and control states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_EQL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_SLTU = 4'd10,
        OP_MUL  = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    // Codes 12..15 have no operation behind them and raise the error output.
    function automatic logic isReservedOp(input logic [3:0] op);
        return (op >= 4'd12);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per step, final sum presented
// combinationally on the last step so the top can register it without an extra cycle.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_lo_o,
    output logic             hi_nonzero_o
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] accSum;

    assign addend       = mplier_q[0] ? mcand_q : '0;
    assign accSum       = acc_q + addend;
    assign done_o       = (cnt_q == CNT_W'(1));
    assign product_lo_o = accSum[WIDTH-1:0];
    assign hi_nonzero_o = |accSum[2*WIDTH-1:WIDTH];

    // Load operands on start, then fold in one multiplier bit per step until the last
    // bit remains; the last bit is added combinationally so the accumulator freezes there.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (step_i && (cnt_q > CNT_W'(1))) begin
            acc_q    <= accSum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides; single-cycle ops stream at full rate,
// MUL runs through the iterative multiplier and blocks new issue until it retires.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] alu_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [3:0]       flags_o,
    output logic             err_o
);
    import alu_pkg::*;

    localparam int SHIFT_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic             outValid_q;
    logic [WIDTH-1:0] aluOut_q;
    logic [TAG_W-1:0] tagOut_q;
    alu_flags_t       flagsOut_q;
    logic             errOut_q;
    logic [TAG_W-1:0] mulTag_q;

    logic             slotFree;
    logic             accept;
    logic             mulStart;
    logic             loadSingle;
    logic             mulFinish;
    logic             mulDone;
    logic [WIDTH-1:0] mulLo;
    logic             mulHiNz;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHIFT_W-1:0] shamt;
    logic [WIDTH-1:0] opResult;
    logic             opCarry;
    logic             opOvf;
    logic             opErr;
    alu_flags_t       opFlags;

    assign slotFree   = !outValid_q || out_ready_i;
    assign in_ready_o = (state_q == IDLE) && slotFree;
    assign accept     = in_valid_i && in_ready_o;
    assign mulStart   = accept && (op_i == OP_MUL);
    assign loadSingle = accept && (op_i != OP_MUL);
    assign mulFinish  = (state_q == MUL) && mulDone && slotFree;

    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign shamt = b_i[SHIFT_W-1:0];

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start_i      (mulStart),
        .a_i          (a_i),
        .b_i          (b_i),
        .step_i       (state_q == MUL),
        .done_o       (mulDone),
        .product_lo_o (mulLo),
        .hi_nonzero_o (mulHiNz)
    );

    // Single-cycle result and carry/overflow selection; reserved codes yield zero and an error.
    always_comb begin
        opResult = '0;
        opCarry  = 1'b0;
        opOvf    = 1'b0;
        opErr    = 1'b0;
        case (op_i)
            OP_ADD: begin
                opResult = sum[WIDTH-1:0];
                opCarry  = sum[WIDTH];
                opOvf    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                opResult = diff[WIDTH-1:0];
                opCarry  = (a_i < b_i);
                opOvf    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLL:  opResult = a_i << shamt;
            OP_SRL:  opResult = a_i >> shamt;
            OP_AND:  opResult = a_i & b_i;
            OP_OR:   opResult = a_i | b_i;
            OP_XOR:  opResult = a_i ^ b_i;
            OP_EQL:  opResult = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            OP_SRA:  opResult = WIDTH'($signed(a_i) >>> shamt);
            OP_SLT:  opResult = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: opResult = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: opErr    = isReservedOp(op_i);
        endcase
        opFlags.zero  = (opResult == '0) && !opErr;
        opFlags.neg   = opResult[WIDTH-1];
        opFlags.carry = opCarry;
        opFlags.ovf   = opOvf;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter MUL on an accepted multiply, leave once the product can be written out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mulStart)  state_d = MUL;
            MUL:     if (mulFinish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tag of the multiply in flight, returned when its product retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            mulTag_q <= '0;
        end else if (mulStart) begin
            mulTag_q <= tag_i;
        end
    end

    // Output slot: load a new result when one is ready, drop valid once consumed,
    // otherwise hold everything stable under back-pressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            aluOut_q   <= '0;
            tagOut_q   <= '0;
            flagsOut_q <= '0;
            errOut_q   <= 1'b0;
        end else if (loadSingle) begin
            outValid_q <= 1'b1;
            aluOut_q   <= opResult;
            tagOut_q   <= tag_i;
            flagsOut_q <= opFlags;
            errOut_q   <= opErr;
        end else if (mulFinish) begin
            outValid_q <= 1'b1;
            aluOut_q   <= mulLo;
            tagOut_q   <= mulTag_q;
            flagsOut_q <= '{zero: (mulLo == '0), neg: mulLo[WIDTH-1], carry: 1'b0, ovf: mulHiNz};
            errOut_q   <= 1'b0;
        end else if (out_ready_i) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid_o = outValid_q;
    assign alu_o       = aluOut_q;
    assign tag_o       = tagOut_q;
    assign flags_o     = flagsOut_q;
    assign err_o       = errOut_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8, TAG_W=4.
module tb_alu_pipe;

    logic       clk;
    logic       reset;
    logic       inValid;
    logic       inReady;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic [3:0] opIn;
    logic [3:0] tagIn;
    logic       outValid;
    logic       outReady;
    logic [7:0] aluOut;
    logic [3:0] tagOut;
    logic [3:0] flagsOut;
    logic       errOut;

    int testsRun  = 0;
    int testsFail = 0;

    // Directed single-cycle vectors: op, a, b, expected result, expected {zero,neg,carry,ovf}.
    localparam int NV = 14;
    logic [3:0] vOp   [NV] = '{4'd0, 4'd0, 4'd1, 4'd8, 4'd3, 4'd9, 4'd10,
                               4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd8};
    logic [7:0] vA    [NV] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'h80, 8'hFF, 8'hFF,
                               8'h01, 8'hF0, 8'hF0, 8'h5A, 8'h5A, 8'h80, 8'h80};
    logic [7:0] vB    [NV] = '{8'h01, 8'h01, 8'h01, 8'h03, 8'h03, 8'h01, 8'h01,
                               8'h07, 8'h3C, 8'h0F, 8'h5A, 8'h5A, 8'h01, 8'h0B};
    logic [7:0] vRes  [NV] = '{8'h00, 8'h80, 8'hFF, 8'hF0, 8'h10, 8'h01, 8'h00,
                               8'h80, 8'h30, 8'hFF, 8'h00, 8'h01, 8'h7F, 8'hF0};
    logic [3:0] vFlag [NV] = '{4'b1010, 4'b0101, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b1000,
                               4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0001, 4'b0100};

    alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .a_i         (aIn),
        .b_i         (bIn),
        .op_i        (opIn),
        .tag_i       (tagIn),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .alu_o       (aluOut),
        .tag_o       (tagOut),
        .flags_o     (flagsOut),
        .err_o       (errOut)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation and hold it until the edge that accepts it; returns #1 after that edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] tag);
        int w;
        w       = 0;
        inValid = 1'b1;
        opIn    = op;
        aIn     = a;
        bIn     = b;
        tagIn   = tag;
        while (!inReady && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Wait for a multiply result, returning edges since acceptance and whether issue ever opened.
    task automatic waitMul(output int lat, output logic sawReady);
        lat      = 0;
        sawReady = 1'b0;
        while (!outValid && lat < 20) begin
            if (inReady) sawReady = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int         lat;
        logic       sawReady;
        int         sendIdx;
        int         recvIdx;
        int         cyc;
        logic       holding;
        logic [7:0] heldAlu;
        logic [3:0] heldTag;
        logic       acc;
        int         staleCount;

        reset    = 1'b1;
        inValid  = 1'b0;
        aIn      = '0;
        bIn      = '0;
        opIn     = '0;
        tagIn    = '0;
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(outValid), 32'd0);
        checkOutput("rst_alu",   32'(aluOut),   32'd0);
        checkOutput("rst_tag",   32'(tagOut),   32'd0);
        checkOutput("rst_flags", 32'(flagsOut), 32'd0);
        checkOutput("rst_err",   32'(errOut),   32'd0);
        checkOutput("rst_ready", 32'(inReady),  32'd1);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vOp[i], vA[i], vB[i], 4'(i));
            checkOutput($sformatf("v%0d_valid", i), 32'(outValid), 32'd1);
            checkOutput($sformatf("v%0d_alu", i),   32'(aluOut),   32'(vRes[i]));
            checkOutput($sformatf("v%0d_flags", i), 32'(flagsOut), 32'(vFlag[i]));
            checkOutput($sformatf("v%0d_tag", i),   32'(tagOut),   32'(i));
            checkOutput($sformatf("v%0d_err", i),   32'(errOut),   32'd0);
        end

        applyStimulus(4'd13, 8'h12, 8'h34, 4'hD);
        checkOutput("rsv_err",   32'(errOut),   32'd1);
        checkOutput("rsv_alu",   32'(aluOut),   32'd0);
        checkOutput("rsv_flags", 32'(flagsOut), 32'd0);
        applyStimulus(4'd0, 8'h01, 8'h01, 4'hE);
        checkOutput("rsv_clear_err", 32'(errOut), 32'd0);

        applyStimulus(4'd11, 8'd13, 8'd11, 4'h5);
        waitMul(lat, sawReady);
        checkOutput("mul1_latency", 32'(lat),      32'd8);
        checkOutput("mul1_ready0",  32'(sawReady), 32'd0);
        checkOutput("mul1_alu",     32'(aluOut),   32'h8F);
        checkOutput("mul1_flags",   32'(flagsOut), 32'b0100);
        checkOutput("mul1_tag",     32'(tagOut),   32'h5);

        applyStimulus(4'd11, 8'h10, 8'h10, 4'h6);
        waitMul(lat, sawReady);
        checkOutput("mul2_latency", 32'(lat),      32'd8);
        checkOutput("mul2_alu",     32'(aluOut),   32'h00);
        checkOutput("mul2_flags",   32'(flagsOut), 32'b1001);
        checkOutput("mul2_tag",     32'(tagOut),   32'h6);

        @(posedge clk);
        #1;
        checkOutput("bp_idle_valid", 32'(outValid), 32'd0);

        sendIdx = 0;
        recvIdx = 0;
        holding = 1'b0;
        heldAlu = '0;
        heldTag = '0;
        cyc     = 0;
        while (recvIdx < 6 && cyc < 40) begin
            outReady = !(cyc >= 2 && cyc < 7);
            if (sendIdx < 6) begin
                inValid = 1'b1;
                opIn    = 4'd0;
                aIn     = 8'(sendIdx * 16 + 3);
                bIn     = 8'h01;
                tagIn   = 4'(sendIdx + 8);
            end else begin
                inValid = 1'b0;
            end
            #1;
            acc = inValid && inReady;
            if (outValid && outReady) begin
                checkOutput($sformatf("bp_tag%0d", recvIdx), 32'(tagOut), 32'(recvIdx + 8));
                checkOutput($sformatf("bp_alu%0d", recvIdx), 32'(aluOut), 32'(recvIdx * 16 + 4));
                recvIdx++;
            end
            if (outValid && !outReady) begin
                checkOutput("bp_stall_ready", 32'(inReady), 32'd0);
                if (holding) begin
                    checkOutput("bp_hold_alu", 32'(aluOut), 32'(heldAlu));
                    checkOutput("bp_hold_tag", 32'(tagOut), 32'(heldTag));
                end
                holding = 1'b1;
                heldAlu = aluOut;
                heldTag = tagOut;
            end else begin
                holding = 1'b0;
            end
            @(posedge clk);
            #1;
            if (acc) sendIdx++;
            cyc++;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("bp_received", 32'(recvIdx), 32'd6);
        @(posedge clk);
        #1;
        checkOutput("bp_no_dup", 32'(outValid), 32'd0);

        applyStimulus(4'd11, 8'd13, 8'd11, 4'h7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mrst_valid", 32'(outValid), 32'd0);
        checkOutput("mrst_ready", 32'(inReady),  32'd1);
        staleCount = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (outValid) staleCount++;
        end
        checkOutput("mrst_no_stale", 32'(staleCount), 32'd0);

        applyStimulus(4'd13, 8'hAA, 8'h55, 4'h3);
        checkOutput("rsv2_err", 32'(errOut), 32'd1);
        checkOutput("rsv2_alu", 32'(aluOut), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
